spram_arbiter: RTL and testbench
================================

# spram_arbiter

Two-requester arbiter and power sequencer for one iCE40UP single-port SPRAM (16K x 16, SB_SPRAM256KA primitive). It shares the RAM between the CPU data port (A) and a DMA/video fetch port (B) with round-robin fairness. Each cycle it drives the primitive's address, data, mask and write-enable pins from the granted requester and returns read data one cycle later. Optionally, it puts the macro to sleep after a run of idle cycles and sequences wake-up.

## Interface
- `ADDR_W`, 14: word address width; must match the SPRAM depth.
- `IDLE_CYCLES`, 64: consecutive idle ACTIVE cycles before entering sleep (≥2).
- `WAKE_CYCLES`, 3: cycles spent in WAKE before accepting requests (≥1).

- `clock`  in  1  single clock for the block and the SPRAM.
- `reset`  in  1  synchronous, active-high.
- `a_req`, `b_req`  in  1  request; held stable with its fields until acked.
- `a_we`, `b_we`  in  1  1 = write, 0 = read.
- `a_mask`, `b_mask`  in  4  nibble write mask, passed to MASKWREN.
- `a_addr`, `b_addr`  in  ADDR_W  word address.
- `a_wdata`, `b_wdata`  in  16  write data.
- `a_ack`, `b_ack`  out  1  request accepted at this clock edge.
- `a_rvalid`, `b_rvalid`  out  1  read data valid this cycle.
- `a_rdata`, `b_rdata`  out  16  read data; both driven from `ram_dataout`.
- `ram_address`  out  ADDR_W  to SPRAM ADDRESS.
- `ram_datain`  out  16  to SPRAM DATAIN.
- `ram_maskwren`  out  4  to SPRAM MASKWREN.
- `ram_wren`  out  1  to SPRAM WREN.
- `ram_chipselect`  out  1  to SPRAM CHIPSELECT.
- `ram_standby`  out  1  to SPRAM STANDBY; constant 0.
- `ram_sleep`  out  1  to SPRAM SLEEP.
- `ram_poweroff`  out  1  to SPRAM POWEROFF (active-low); constant 1.
- `ram_dataout`  in  16  from SPRAM DATAOUT.

## Operation
- States: ACTIVE, SLEEP, WAKE. Reset state is ACTIVE.
- ACTIVE arbitration is combinational from `a_req`/`b_req`:
  - Only one port requesting: that port is granted.
  - Both requesting: grant the port opposite `last_grant`.
  - `last_grant` is a register that updates on every ack; its reset value is B, so A wins the first tie.
- SPRAM pins follow the granted port in the same cycle:
  - `ram_chipselect`=1, `ram_address`=addr, `ram_datain`=wdata, `ram_wren`=we.
  - `ram_maskwren` = mask on a write; 0 on a read.
  - With no grant: chipselect, wren and maskwren are 0; address and data are don't-care but driven from A.
- The ack for the granted port is high in the same cycle. The transfer occurs at that rising edge.
- A read accepted at edge N sets that port's `rvalid` for exactly the cycle after N. The port samples its `rdata` in that cycle.
- Idle counter:
  - Counts ACTIVE cycles with no request and no rvalid.
  - Clears on any request.
  - Reaching `IDLE_CYCLES`-1 while still idle moves the block to SLEEP at the next edge.
- SLEEP:
  - `ram_sleep`=1, chipselect=0, no acks.
  - Any request moves the block to WAKE at the next edge.
- WAKE:
  - `ram_sleep`=0, chipselect=0, no acks.
  - Stays for exactly `WAKE_CYCLES` cycles, then goes to ACTIVE.
  - Requests are held by the requesters and granted normally in the first ACTIVE cycle.
- Reset values:
  - Outputs: acks 0, rvalids 0, `ram_sleep` 0, `ram_chipselect` 0, `ram_wren` 0, `ram_maskwren` 0.
  - State and counters: ACTIVE, both counters 0.
- Reset mid-read: the pending rvalid is dropped, and no rvalid appears after reset.

## Timing
- Throughput is one access per cycle, with back-to-back accesses from either port.
- Read latency is 1 cycle from ack to rvalid. Write completes at the ack edge.
- With both ports continuously requesting, grants alternate A, B, A, B…
- Read-after-write to the same address on consecutive cycles returns the new data.
- Sleep entry: `ram_sleep` rises after exactly `IDLE_CYCLES` consecutive idle cycles.
- Wake: a request first seen in SLEEP cycle t is acked at cycle t+1+`WAKE_CYCLES`.
- A request arriving in the same cycle the idle count expires is granted; sleep is not entered.

## Configuration
- `SPRAM_ARB_SLEEP_EN` defined: SLEEP/WAKE states, the idle counter and the wake counter are present, as described above.
- `SPRAM_ARB_SLEEP_EN` undefined:
  - The block stays in ACTIVE permanently.
  - `ram_sleep` is tied 0; the idle and wake counters are removed.
  - `IDLE_CYCLES` and `WAKE_CYCLES` are ignored.

## Test plan
- A writes 0xBEEF to 0x0010 with mask 0xF, then reads 0x0010 → `a_ack` high one cycle each; `a_rvalid` high the cycle after the read ack with `a_rdata`=0xBEEF.
- A and B request continuously: A reads 0x0001, B reads 0x0002 → acks alternate starting with A; each rvalid/rdata lands on the correct port one cycle after its ack.
- Masked write: write 0xFFFF, then write 0x1234 with mask 0b0011, then read → 0xFF34.
- Sleep: with `SPRAM_ARB_SLEEP_EN`, IDLE_CYCLES=8 and WAKE_CYCLES=3, go idle for 8 cycles → `ram_sleep` rises. B requests in SLEEP cycle t → `ram_sleep` drops at t+1, `b_ack` at t+4, and data written before sleep reads back intact.
- Reset mid-read: assert `reset` on the cycle after A's read ack → `a_rvalid`=0, all outputs at reset values, and the first A/B tie after reset grants A.

Source files
------------

// File: rtl/spram_arbiter.sv
// ---------------------------------------------------------------------------
// spram_arbiter
//   Shares one iCE40UP SB_SPRAM256KA (16K x 16) between a CPU data port (A)
//   and a DMA/video fetch port (B) with round-robin fairness on ties.
//   The granted port drives the SPRAM pins in the same cycle it is acked;
//   read data is returned on that port one cycle later.
//
//   Optional power sequencing (macro SPRAM_ARB_SLEEP_EN): after IDLE_CYCLES
//   consecutive idle cycles the macro is put to sleep; a request wakes it and
//   is granted once WAKE_CYCLES wake cycles have elapsed.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   a_* / b_*             requester ports: req/we/mask/addr/wdata in,
//                         ack/rvalid/rdata out
//   ram_*                 SPRAM primitive pins (ram_dataout is the input)
// ---------------------------------------------------------------------------
module spram_arbiter #(
   parameter int ADDR_W      = 14,
   parameter int IDLE_CYCLES = 64,
   parameter int WAKE_CYCLES = 3
) (
   input  logic              clock,
   input  logic              reset,
   // port A
   input  logic              a_req,
   input  logic              a_we,
   input  logic [3:0]        a_mask,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [15:0]       a_wdata,
   output logic              a_ack,
   output logic              a_rvalid,
   output logic [15:0]       a_rdata,
   // port B
   input  logic              b_req,
   input  logic              b_we,
   input  logic [3:0]        b_mask,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [15:0]       b_wdata,
   output logic              b_ack,
   output logic              b_rvalid,
   output logic [15:0]       b_rdata,
   // SPRAM primitive
   output logic [ADDR_W-1:0] ram_address,
   output logic [15:0]       ram_datain,
   output logic [3:0]        ram_maskwren,
   output logic              ram_wren,
   output logic              ram_chipselect,
   output logic              ram_standby,
   output logic              ram_sleep,
   output logic              ram_poweroff,
   input  logic [15:0]       ram_dataout
);

   if (IDLE_CYCLES < 2) begin : g_chk_idle
      $error("spram_arbiter: IDLE_CYCLES must be >= 2");
   end
   if (WAKE_CYCLES < 1) begin : g_chk_wake
      $error("spram_arbiter: WAKE_CYCLES must be >= 1");
   end

   logic last_grant_q, last_grant_d;   // 0 = A, 1 = B
   logic a_rvalid_q, a_rvalid_d;
   logic b_rvalid_q, b_rvalid_d;
   logic active;
   logic gnt_a, gnt_b;

`ifdef SPRAM_ARB_SLEEP_EN
   localparam logic [1:0] ST_ACTIVE = 2'd0;
   localparam logic [1:0] ST_SLEEP  = 2'd1;
   localparam logic [1:0] ST_WAKE   = 2'd2;

   localparam int IDLE_W = $clog2(IDLE_CYCLES);
   localparam int WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
   localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
   logic [WAKE_W-1:0] wake_cnt_q, wake_cnt_d;
   logic              idle;

   // An outstanding rvalid keeps the block awake so the read data is
   // delivered before the macro goes to sleep.
   assign idle = ~a_req & ~b_req & ~a_rvalid_q & ~b_rvalid_q;

   // Counters return to 0 whenever they are not actively counting, so both
   // always start from 0 on entry to their state.
   always_comb begin
      state_d    = state_q;
      idle_cnt_d = '0;
      wake_cnt_d = '0;
      case (state_q)
         ST_ACTIVE: begin
            if (idle) begin
               if (idle_cnt_q == IDLE_LAST) state_d = ST_SLEEP;
               else                         idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         ST_SLEEP: begin
            if (a_req | b_req) state_d = ST_WAKE;
         end
         ST_WAKE: begin
            if (wake_cnt_q == WAKE_LAST) state_d = ST_ACTIVE;
            else                         wake_cnt_d = wake_cnt_q + 1'b1;
         end
         default: state_d = ST_ACTIVE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_ACTIVE;
         idle_cnt_q <= '0;
         wake_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         idle_cnt_q <= idle_cnt_d;
         wake_cnt_q <= wake_cnt_d;
      end
   end

   assign active    = (state_q == ST_ACTIVE);
   assign ram_sleep = (state_q == ST_SLEEP) & ~reset;
`else
   assign active    = 1'b1;
   assign ram_sleep = 1'b0;
`endif

   // Grants are combinational; a tie goes to the port that did not win last.
   // Reset masks them so no access leaks out while reset is held.
   assign gnt_a = ~reset & active & a_req & (~b_req |  last_grant_q);
   assign gnt_b = ~reset & active & b_req & (~a_req | ~last_grant_q);

   always_comb begin
      last_grant_d = last_grant_q;
      if (gnt_a) last_grant_d = 1'b0;
      if (gnt_b) last_grant_d = 1'b1;
      a_rvalid_d = gnt_a & ~a_we;
      b_rvalid_d = gnt_b & ~b_we;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         last_grant_q <= 1'b1;
         a_rvalid_q   <= 1'b0;
         b_rvalid_q   <= 1'b0;
      end else begin
         last_grant_q <= last_grant_d;
         a_rvalid_q   <= a_rvalid_d;
         b_rvalid_q   <= b_rvalid_d;
      end
   end

   assign a_ack    = gnt_a;
   assign b_ack    = gnt_b;
   // A read acked just before reset is dropped, not delivered during reset.
   assign a_rvalid = a_rvalid_q & ~reset;
   assign b_rvalid = b_rvalid_q & ~reset;
   assign a_rdata  = ram_dataout;
   assign b_rdata  = ram_dataout;

   // Address/data default to port A when nothing is granted.
   assign ram_address    = gnt_b ? b_addr  : a_addr;
   assign ram_datain     = gnt_b ? b_wdata : a_wdata;
   assign ram_chipselect = gnt_a | gnt_b;
   assign ram_wren       = (gnt_a & a_we) | (gnt_b & b_we);
   assign ram_maskwren   = (gnt_a & a_we) ? a_mask :
                           (gnt_b & b_we) ? b_mask : 4'h0;
   assign ram_standby    = 1'b0;
   assign ram_poweroff   = 1'b1;

endmodule

// File: tb/tb_spram_arbiter.sv
module tb_spram_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        a_req, a_we, b_req, b_we;
   logic [3:0]  a_mask, b_mask;
   logic [13:0] a_addr, b_addr;
   logic [15:0] a_wdata, b_wdata;
   logic        a_ack, a_rvalid, b_ack, b_rvalid;
   logic [15:0] a_rdata, b_rdata;
   logic [13:0] ram_address;
   logic [15:0] ram_datain, ram_dataout;
   logic [3:0]  ram_maskwren;
   logic        ram_wren, ram_chipselect, ram_standby, ram_sleep, ram_poweroff;

   int checks = 0;
   int fails  = 0;

   always #5 clock = ~clock;

   spram_arbiter #(.ADDR_W(14), .IDLE_CYCLES(8), .WAKE_CYCLES(3)) dut (
      .clock(clock), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_mask(a_mask), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_ack(a_ack), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_mask(b_mask), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_ack(b_ack), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .ram_address(ram_address), .ram_datain(ram_datain), .ram_maskwren(ram_maskwren),
      .ram_wren(ram_wren), .ram_chipselect(ram_chipselect), .ram_standby(ram_standby),
      .ram_sleep(ram_sleep), .ram_poweroff(ram_poweroff), .ram_dataout(ram_dataout)
   );

   // behavioural SPRAM: registered read, nibble write enables
   logic [15:0] mem [0:16383];
   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = 16'h0;
      ram_dataout = 16'h0;
   end
   always @(posedge clock) begin
      if (ram_chipselect && !ram_sleep) begin
         if (ram_wren) begin
            for (int n = 0; n < 4; n++)
               if (ram_maskwren[n]) mem[ram_address][n*4 +: 4] <= ram_datain[n*4 +: 4];
         end else begin
            ram_dataout <= mem[ram_address];
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_in();
      a_req = 0; a_we = 0; a_mask = 0; a_addr = 0; a_wdata = 0;
      b_req = 0; b_we = 0; b_mask = 0; b_addr = 0; b_wdata = 0;
   endtask

   typedef struct {
      logic ar, aw; logic [3:0] am; logic [13:0] aa; logic [15:0] ad;
      logic br, bw; logic [3:0] bm; logic [13:0] ba; logic [15:0] bd;
      logic eak, ebk, eav, ebv; logic [15:0] erd;
      logic ecs, ewe; logic [3:0] emk; logic [13:0] ead;
   } vec_t;

   function automatic vec_t v(
      input logic ar, aw, input logic [3:0] am, input logic [13:0] aa, input logic [15:0] ad,
      input logic br, bw, input logic [3:0] bm, input logic [13:0] ba, input logic [15:0] bd,
      input logic eak, ebk, eav, ebv, input logic [15:0] erd,
      input logic ecs, ewe, input logic [3:0] emk, input logic [13:0] ead);
      vec_t r;
      r.ar = ar; r.aw = aw; r.am = am; r.aa = aa; r.ad = ad;
      r.br = br; r.bw = bw; r.bm = bm; r.ba = ba; r.bd = bd;
      r.eak = eak; r.ebk = ebk; r.eav = eav; r.ebv = ebv; r.erd = erd;
      r.ecs = ecs; r.ewe = ewe; r.emk = emk; r.ead = ead;
      return r;
   endfunction

   vec_t vt [14];

   initial begin
      //          A: req we mask addr  wdata   B: req we mask addr wdata  exp: aak bak av bv rdata    cs we mk  addr
      vt[0]  = v(1,1,4'hF,14'h10,16'hBEEF, 0,0,4'h0,14'h0,16'h0,      1,0,0,0,16'h0,    1,1,4'hF,14'h10);
      vt[1]  = v(1,0,4'hF,14'h10,16'h0,    0,0,4'h0,14'h0,16'h0,      1,0,0,0,16'h0,    1,0,4'h0,14'h10);
      vt[2]  = v(0,0,4'h0,14'h0,16'h0,     0,0,4'h0,14'h0,16'h0,      0,0,1,0,16'hBEEF, 0,0,4'h0,14'h0);
      vt[3]  = v(1,1,4'hF,14'h1,16'h1111,  0,0,4'h0,14'h0,16'h0,      1,0,0,0,16'h0,    1,1,4'hF,14'h1);
      vt[4]  = v(0,0,4'h0,14'h0,16'h0,     1,1,4'hF,14'h2,16'h2222,   0,1,0,0,16'h0,    1,1,4'hF,14'h2);
      vt[5]  = v(1,0,4'h0,14'h1,16'h0,     1,0,4'h0,14'h2,16'h0,      1,0,0,0,16'h0,    1,0,4'h0,14'h1);
      vt[6]  = v(1,0,4'h0,14'h1,16'h0,     1,0,4'h0,14'h2,16'h0,      0,1,1,0,16'h1111, 1,0,4'h0,14'h2);
      vt[7]  = v(1,0,4'h0,14'h1,16'h0,     1,0,4'h0,14'h2,16'h0,      1,0,0,1,16'h2222, 1,0,4'h0,14'h1);
      vt[8]  = v(1,0,4'h0,14'h1,16'h0,     1,0,4'h0,14'h2,16'h0,      0,1,1,0,16'h1111, 1,0,4'h0,14'h2);
      vt[9]  = v(0,0,4'h0,14'h0,16'h0,     0,0,4'h0,14'h0,16'h0,      0,0,0,1,16'h2222, 0,0,4'h0,14'h0);
      vt[10] = v(1,1,4'hF,14'h20,16'hFFFF, 0,0,4'h0,14'h0,16'h0,      1,0,0,0,16'h0,    1,1,4'hF,14'h20);
      vt[11] = v(1,1,4'h3,14'h20,16'h1234, 0,0,4'h0,14'h0,16'h0,      1,0,0,0,16'h0,    1,1,4'h3,14'h20);
      vt[12] = v(1,0,4'hF,14'h20,16'h0,    0,0,4'h0,14'h0,16'h0,      1,0,0,0,16'h0,    1,0,4'h0,14'h20);
      vt[13] = v(0,0,4'h0,14'h0,16'h0,     0,0,4'h0,14'h0,16'h0,      0,0,1,0,16'hFF34, 0,0,4'h0,14'h0);

      // reset with both ports requesting: everything must stay quiet
      reset = 1; idle_in(); a_req = 1; b_req = 1; a_we = 1; a_mask = 4'hF;
      cyc(); cyc(); #2;
      chk("rst_a_ack", a_ack, 0);        chk("rst_b_ack", b_ack, 0);
      chk("rst_a_rvalid", a_rvalid, 0);  chk("rst_b_rvalid", b_rvalid, 0);
      chk("rst_cs", ram_chipselect, 0);  chk("rst_wren", ram_wren, 0);
      chk("rst_mask", ram_maskwren, 0);  chk("rst_sleep", ram_sleep, 0);
      chk("rst_standby", ram_standby, 0); chk("rst_poweroff", ram_poweroff, 1);
      cyc(); reset = 0; idle_in();

      for (int i = 0; i < 14; i++) begin
         cyc();
         a_req = vt[i].ar; a_we = vt[i].aw; a_mask = vt[i].am; a_addr = vt[i].aa; a_wdata = vt[i].ad;
         b_req = vt[i].br; b_we = vt[i].bw; b_mask = vt[i].bm; b_addr = vt[i].ba; b_wdata = vt[i].bd;
         #2;
         chk($sformatf("v%0d_a_ack", i), a_ack, vt[i].eak);
         chk($sformatf("v%0d_b_ack", i), b_ack, vt[i].ebk);
         chk($sformatf("v%0d_a_rvalid", i), a_rvalid, vt[i].eav);
         chk($sformatf("v%0d_b_rvalid", i), b_rvalid, vt[i].ebv);
         if (vt[i].eav) chk($sformatf("v%0d_a_rdata", i), a_rdata, vt[i].erd);
         if (vt[i].ebv) chk($sformatf("v%0d_b_rdata", i), b_rdata, vt[i].erd);
         chk($sformatf("v%0d_cs", i), ram_chipselect, vt[i].ecs);
         chk($sformatf("v%0d_wren", i), ram_wren, vt[i].ewe);
         chk($sformatf("v%0d_mask", i), ram_maskwren, vt[i].emk);
         if (vt[i].ecs) chk($sformatf("v%0d_addr", i), ram_address, vt[i].ead);
         if (vt[i].ewe) chk($sformatf("v%0d_datain", i), ram_datain, vt[i].eak ? vt[i].ad : vt[i].bd);
      end
      cyc(); idle_in();

`ifdef SPRAM_ARB_SLEEP_EN
      // this cycle is idle #1; sleep must rise after exactly 8 idle cycles
      for (int k = 1; k < 8; k++) begin
         cyc();
         #2 chk($sformatf("sleep_early_%0d", k), ram_sleep, 0);
      end
      cyc(); #2;
      chk("sleep_enter", ram_sleep, 1);
      chk("sleep_cs", ram_chipselect, 0);
      // B request first seen in SLEEP cycle t
      cyc(); b_req = 1; b_we = 0; b_addr = 14'h20; #2;
      chk("wake_t_back", b_ack, 0);
      chk("wake_t_sleep", ram_sleep, 1);
      cyc(); #2;
      chk("wake_t1_sleep", ram_sleep, 0);
      chk("wake_t1_back", b_ack, 0);
      chk("wake_t1_cs", ram_chipselect, 0);
      cyc(); #2 chk("wake_t2_back", b_ack, 0);
      cyc(); #2 chk("wake_t3_back", b_ack, 0);
      cyc(); #2;
      chk("wake_t4_back", b_ack, 1);
      chk("wake_t4_cs", ram_chipselect, 1);
      cyc(); idle_in(); #2;
      chk("wake_rvalid", b_rvalid, 1);
      chk("wake_rdata", b_rdata, 16'hFF34);
      // request in the very cycle the idle count expires wins over sleep
      for (int k = 0; k < 7; k++) cyc();
      cyc(); a_req = 1; a_we = 0; a_addr = 14'h10; #2;
      chk("race_ack", a_ack, 1);
      chk("race_sleep", ram_sleep, 0);
      cyc(); idle_in(); #2;
      chk("race_no_sleep", ram_sleep, 0);
      chk("race_rdata", a_rvalid ? a_rdata : 16'hDEAD, 16'hBEEF);
`else
      begin
         int seen = 0;
         for (int k = 0; k < 80; k++) begin
            cyc(); #2;
            if (ram_sleep) seen++;
         end
         chk("nosleep_sleep", seen, 0);
      end
      cyc(); a_req = 1; a_we = 0; a_addr = 14'h10; #2;
      chk("nosleep_ack", a_ack, 1);
      cyc(); idle_in(); #2;
      chk("nosleep_rdata", a_rvalid ? a_rdata : 16'hDEAD, 16'hBEEF);
`endif

      // reset in the cycle after a read ack drops the rvalid
      cyc(); a_req = 1; a_we = 0; a_addr = 14'h10; #2;
      chk("mrd_ack", a_ack, 1);
      cyc(); idle_in(); reset = 1; #2;
      chk("mrd_a_rvalid", a_rvalid, 0);
      chk("mrd_b_rvalid", b_rvalid, 0);
      chk("mrd_cs", ram_chipselect, 0);
      chk("mrd_wren", ram_wren, 0);
      chk("mrd_mask", ram_maskwren, 0);
      chk("mrd_sleep", ram_sleep, 0);
      cyc(); reset = 0; #2;
      chk("mrd_post_rvalid", a_rvalid, 0);
      cyc(); a_req = 1; b_req = 1; #2;
      chk("mrd_tie_a", a_ack, 1);
      chk("mrd_tie_b", b_ack, 0);
      cyc(); a_req = 0; #2;
      chk("mrd_next_b", b_ack, 1);
      cyc(); idle_in();
      cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
